// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel programmable clock-enable generator.
// Each channel divides clk by (D+1) and produces a one-cycle tick plus a
// 50%-duty square wave. New divisors are held in a shadow register and take
// effect at the next period boundary, so a running channel never glitches.
// A global sync restarts every channel at phase zero.
module clk_en_gen #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 16,
  parameter int RESET_DIV = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] div_val,
  input  logic [CHANNELS-1:0]       div_load,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       pending
);

  localparam logic [WIDTH-1:0] RESET_D = WIDTH'(RESET_DIV);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] d_act_q, d_act_d;
    logic [WIDTH-1:0] d_shd_q, d_shd_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] load_val;
    logic             load;

    assign load_val = div_val[gi*WIDTH +: WIDTH];
    assign load     = div_load[gi];

    // Next-state: sync beats disable, disable beats counting. The counter
    // only ever compares for equality with d_act, so it can never run past
    // the terminal count even at the all-ones divisor.
    always_comb begin
      cnt_d     = cnt_q;
      d_act_d   = d_act_q;
      d_shd_d   = d_shd_q;
      tick_d    = 1'b0;
      clk_out_d = clk_out_q;
      pending_d = pending_q;
      if (sync) begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        if (load) begin
          d_act_d = load_val;
        end else if (pending_q) begin
          d_act_d = d_shd_q;
        end
        pending_d = 1'b0;
      end else if (!en[gi]) begin
        // Disabled: phase frozen, but a new divisor applies at once and
        // restarts the period since there is no running period to protect.
        if (load) begin
          d_act_d   = load_val;
          cnt_d     = '0;
          pending_d = 1'b0;
        end else if (pending_q) begin
          d_act_d   = d_shd_q;
          cnt_d     = '0;
          pending_d = 1'b0;
        end
      end else if (cnt_q == d_act_q) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        clk_out_d = ~clk_out_q;
        if (load) begin
          d_act_d = load_val;
        end else if (pending_q) begin
          d_act_d = d_shd_q;
        end
        pending_d = 1'b0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
        if (load) begin
          d_shd_d   = load_val;
          pending_d = 1'b1;
        end
      end
    end

    // Channel state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        d_act_q   <= RESET_D;
        d_shd_q   <= RESET_D;
        tick_q    <= 1'b0;
        clk_out_q <= 1'b0;
        pending_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        d_act_q   <= d_act_d;
        d_shd_q   <= d_shd_d;
        tick_q    <= tick_d;
        clk_out_q <= clk_out_d;
        pending_q <= pending_d;
      end
    end

    assign tick[gi]    = tick_q;
    assign clk_out[gi] = clk_out_q;
    assign pending[gi] = pending_q;
  end

endmodule
